// File: rtl/router_sync_param_pkg.sv
// Shared definitions for the parametrised router synchroniser: default
// geometry, timeout length and a constant-evaluable clog2 helper.
package router_pkg;

  localparam int ROUTER_DEFAULT_NUM_CH  = 3;
  localparam int ROUTER_DEFAULT_ADDR_W  = 2;
  localparam int ROUTER_DEFAULT_TIMEOUT = 30;

  // Ceiling log2, usable in parameter/localparam expressions.
  // A value of 1 yields 0; callers guarantee value >= 2.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/router_sync_param_if.sv
// Bus between the router FSM/register stage, the output FIFOs and the
// synchroniser. The FSM/FIFO side is the master; the synchroniser is the
// slave and drives the write enables, valids, flush pulses and status.
interface router_sync_param_if
  import router_pkg::*;
#(
  parameter int NUM_CH = ROUTER_DEFAULT_NUM_CH,
  parameter int ADDR_W = ROUTER_DEFAULT_ADDR_W
);

  logic [ADDR_W-1:0] data_in;
  logic              detect_add;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] read_enb;

  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;

  modport master (
    output data_in,
    output detect_add,
    output write_enb_reg,
    output full,
    output empty,
    output read_enb,
    input  write_enb,
    input  fifo_full,
    input  vld_out,
    input  soft_reset,
    input  addr_err
  );

  modport slave (
    input  data_in,
    input  detect_add,
    input  write_enb_reg,
    input  full,
    input  empty,
    input  read_enb,
    output write_enb,
    output fifo_full,
    output vld_out,
    output soft_reset,
    output addr_err
  );

endinterface

// File: rtl/router_sync_param_timeout_ch.sv
// One output channel's stall watchdog. Counts consecutive edges on which the
// channel holds valid data that nobody reads, and emits a one-cycle flush
// pulse every TIMEOUT such edges for as long as the stall lasts.
module router_timeout_ch
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_DEFAULT_TIMEOUT,
  parameter int CNT_W   = clog2(TIMEOUT)
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  // Last count value before the pulse; the counter never goes beyond it,
  // so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stalled;

  assign stalled = vld & ~rd;

  // Stall counter and flush pulse; the TIMEOUT-th stalled edge fires and
  // re-arms, so a persistent stall repeats the pulse every TIMEOUT edges.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!stalled) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_param.sv
// Parametrised router synchroniser. Latches the packet destination on
// detect_add, steers the FSM write request to the addressed FIFO, returns
// that FIFO's full flag, publishes per-channel valid and flushes channels
// whose valid data goes unread for TIMEOUT cycles. Out-of-range addresses
// are flagged and never write any FIFO.
module router_sync_param
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_DEFAULT_NUM_CH,
  parameter int ADDR_W  = ROUTER_DEFAULT_ADDR_W,
  parameter int TIMEOUT = ROUTER_DEFAULT_TIMEOUT
) (
  input  logic         clock,
  input  logic         resetn,
  router_sync_param_if.slave bus
);

  localparam int CNT_W = clog2(TIMEOUT);

  if (NUM_CH < 2) begin : g_bad_num_ch
    $fatal(1, "router_sync_param: NUM_CH must be at least 2");
  end
  if (ADDR_W < clog2(NUM_CH)) begin : g_bad_addr_w
    $fatal(1, "router_sync_param: ADDR_W too narrow for NUM_CH");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $fatal(1, "router_sync_param: TIMEOUT must be at least 2");
  end

  logic [ADDR_W-1:0] addr_q;
  logic              addr_err_q;
  logic              data_in_range;
  logic [NUM_CH-1:0] sel_onehot;
  logic [NUM_CH-1:0] vld;
  logic [NUM_CH-1:0] soft_reset_w;

  // Compare in 32 bits so the check is exact whatever ADDR_W is.
  assign data_in_range = (32'(bus.data_in) < 32'(NUM_CH));

  // Destination latch; an out-of-range address is kept but marked in error
  // until a later in-range header replaces it.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else if (bus.detect_add) begin
      addr_q     <= bus.data_in;
      addr_err_q <= ~data_in_range;
    end
  end

  // While addr_err is clear addr_q is in range, so the one-hot select
  // always names a real FIFO whenever it is used.
  assign sel_onehot = NUM_CH'(1) << addr_q;

  // A header arriving together with a write still steers that write by the
  // previously latched address.
  assign bus.write_enb = (bus.write_enb_reg && !addr_err_q) ? sel_onehot : '0;

  // A nonexistent FIFO reports not-full so the FSM never stalls on it.
  assign bus.fifo_full = !addr_err_q && |(bus.full & sel_onehot);

  assign vld          = ~bus.empty;
  assign bus.vld_out  = vld;
  assign bus.addr_err = addr_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    router_timeout_ch #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timeout (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld[i]),
      .rd         (bus.read_enb[i]),
      .soft_reset (soft_reset_w[i])
    );
  end

  assign bus.soft_reset = soft_reset_w;

endmodule

// File: tb/tb_router_sync_param.sv
// Bench for router_sync_param: a default instance (3 channels, timeout 30)
// and a scaled instance (4 channels, timeout 4) share clock and reset.
// Directed scenarios plus a randomized run against a behavioural model that
// tracks latched address/error and the length of each channel's stall run.
module tb_router_sync_param;

  logic clock;
  logic resetn;

  router_sync_param_if #(.NUM_CH(3), .ADDR_W(2)) ifa ();
  router_sync_param_if #(.NUM_CH(4), .ADDR_W(2)) ifb ();

  router_sync_param #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut_a (
    .clock  (clock),
    .resetn (resetn),
    .bus    (ifa)
  );

  router_sync_param #(.NUM_CH(4), .ADDR_W(2), .TIMEOUT(4)) dut_b (
    .clock  (clock),
    .resetn (resetn),
    .bus    (ifb)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state.
  int         m_addr_a;
  bit         m_err_a;
  int         run_a [3];
  logic [2:0] m_sr_a;
  int         m_addr_b;
  bit         m_err_b;
  int         run_b [4];
  logic [3:0] m_sr_b;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance the model by one rising edge from the currently driven inputs,
  // then wait for that edge and settle 1 time unit past it.
  task automatic step();
    if (!resetn) begin
      m_addr_a = 0; m_err_a = 0; m_sr_a = '0;
      m_addr_b = 0; m_err_b = 0; m_sr_b = '0;
      for (int i = 0; i < 3; i++) run_a[i] = 0;
      for (int i = 0; i < 4; i++) run_b[i] = 0;
    end else begin
      if (ifa.detect_add) begin
        m_addr_a = int'(ifa.data_in);
        m_err_a  = (m_addr_a >= 3);
      end
      if (ifb.detect_add) begin
        m_addr_b = int'(ifb.data_in);
        m_err_b  = (m_addr_b >= 4);
      end
      for (int i = 0; i < 3; i++) begin
        if (!ifa.empty[i] && !ifa.read_enb[i]) begin
          run_a[i]  = run_a[i] + 1;
          m_sr_a[i] = (run_a[i] % 30 == 0);
        end else begin
          run_a[i]  = 0;
          m_sr_a[i] = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!ifb.empty[i] && !ifb.read_enb[i]) begin
          run_b[i]  = run_b[i] + 1;
          m_sr_b[i] = (run_b[i] % 4 == 0);
        end else begin
          run_b[i]  = 0;
          m_sr_b[i] = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ifa.empty = 3'b010; ifa.write_enb_reg = 1'b1;
    step();
    if (ifa.addr_err !== 1'b0) $display("FAIL reset_addr_err got %b want 0", ifa.addr_err);
    else pass_cnt++;
    total_cnt++;
    if (ifa.soft_reset !== 3'b000) $display("FAIL reset_soft_reset got %b want 000", ifa.soft_reset);
    else pass_cnt++;
    total_cnt++;
    if (ifa.write_enb !== 3'b001) $display("FAIL reset_write_enb got %b want 001", ifa.write_enb);
    else pass_cnt++;
    total_cnt++;
    if (ifa.vld_out !== 3'b101) $display("FAIL reset_vld_out got %b want 101", ifa.vld_out);
    else pass_cnt++;
    total_cnt++;
    if (ifb.addr_err !== 1'b0 || ifb.soft_reset !== 4'b0000)
      $display("FAIL reset_b got err=%b sr=%b want 0/0000", ifb.addr_err, ifb.soft_reset);
    else pass_cnt++;
    total_cnt++;
    resetn = 1'b1;
    ifa.empty = 3'b111; ifa.write_enb_reg = 1'b0;
    step();
  endtask

  task automatic test_addr_in_range();
    ifa.detect_add = 1'b1; ifa.data_in = 2'd1;
    step();
    ifa.detect_add = 1'b0; ifa.write_enb_reg = 1'b1;
    #1;
    if (ifa.write_enb !== 3'b010) $display("FAIL addr1_write_enb got %b want 010", ifa.write_enb);
    else pass_cnt++;
    total_cnt++;
    ifa.full = 3'b010;
    #1;
    if (ifa.fifo_full !== 1'b1) $display("FAIL addr1_full_hit got %b want 1", ifa.fifo_full);
    else pass_cnt++;
    total_cnt++;
    ifa.full = 3'b001;
    #1;
    if (ifa.fifo_full !== 1'b0) $display("FAIL addr1_full_other got %b want 0", ifa.fifo_full);
    else pass_cnt++;
    total_cnt++;
    if (ifa.addr_err !== 1'b0) $display("FAIL addr1_addr_err got %b want 0", ifa.addr_err);
    else pass_cnt++;
    total_cnt++;
    ifa.full = 3'b000;
    ifa.write_enb_reg = 1'b0;
  endtask

  task automatic test_same_cycle();
    ifa.detect_add = 1'b1; ifa.data_in = 2'd2; ifa.write_enb_reg = 1'b1;
    #1;
    if (ifa.write_enb !== 3'b010) $display("FAIL same_cycle_old got %b want 010", ifa.write_enb);
    else pass_cnt++;
    total_cnt++;
    step();
    ifa.detect_add = 1'b0;
    #1;
    if (ifa.write_enb !== 3'b100) $display("FAIL same_cycle_new got %b want 100", ifa.write_enb);
    else pass_cnt++;
    total_cnt++;
    ifa.write_enb_reg = 1'b0;
  endtask

  task automatic test_invalid_addr();
    ifa.detect_add = 1'b1; ifa.data_in = 2'd3;
    step();
    ifa.detect_add = 1'b0; ifa.write_enb_reg = 1'b1; ifa.full = 3'b111;
    #1;
    if (ifa.addr_err !== 1'b1) $display("FAIL bad_addr_err got %b want 1", ifa.addr_err);
    else pass_cnt++;
    total_cnt++;
    if (ifa.write_enb !== 3'b000) $display("FAIL bad_addr_write_enb got %b want 000", ifa.write_enb);
    else pass_cnt++;
    total_cnt++;
    if (ifa.fifo_full !== 1'b0) $display("FAIL bad_addr_fifo_full got %b want 0", ifa.fifo_full);
    else pass_cnt++;
    total_cnt++;
    step();
    step();
    if (ifa.addr_err !== 1'b1) $display("FAIL bad_addr_hold got %b want 1", ifa.addr_err);
    else pass_cnt++;
    total_cnt++;
    ifa.detect_add = 1'b1; ifa.data_in = 2'd0;
    step();
    ifa.detect_add = 1'b0;
    #1;
    if (ifa.addr_err !== 1'b0) $display("FAIL bad_addr_clear got %b want 0", ifa.addr_err);
    else pass_cnt++;
    total_cnt++;
    if (ifa.write_enb !== 3'b001) $display("FAIL bad_addr_recover got %b want 001", ifa.write_enb);
    else pass_cnt++;
    total_cnt++;
    ifa.write_enb_reg = 1'b0; ifa.full = 3'b000;
  endtask

  task automatic test_timeout();
    logic [2:0] exp;
    ifa.empty = 3'b111; ifa.read_enb = 3'b000;
    step();
    ifa.empty = 3'b110;
    for (int e = 1; e <= 61; e++) begin
      step();
      exp = (e == 30 || e == 60) ? 3'b001 : 3'b000;
      if (ifa.soft_reset !== exp) $display("FAIL timeout_repeat edge %0d got %b want %b", e, ifa.soft_reset, exp);
      else pass_cnt++;
      total_cnt++;
    end
    ifa.empty = 3'b111;
    step();
    ifa.empty = 3'b110;
    for (int e = 1; e <= 60; e++) begin
      ifa.read_enb = (e == 29) ? 3'b001 : 3'b000;
      step();
      exp = (e == 59) ? 3'b001 : 3'b000;
      if (ifa.soft_reset !== exp) $display("FAIL timeout_read_restart edge %0d got %b want %b", e, ifa.soft_reset, exp);
      else pass_cnt++;
      total_cnt++;
    end
    ifa.empty = 3'b111; ifa.read_enb = 3'b000;
    step();
  endtask

  task automatic test_independent();
    logic [2:0] exp;
    ifa.empty = 3'b010;
    for (int e = 1; e <= 45; e++) begin
      ifa.read_enb = (e == 10) ? 3'b100 : 3'b000;
      step();
      exp = ((e == 30) ? 3'b001 : 3'b000) | ((e == 40) ? 3'b100 : 3'b000);
      if (ifa.soft_reset !== exp) $display("FAIL indep_channels edge %0d got %b want %b", e, ifa.soft_reset, exp);
      else pass_cnt++;
      total_cnt++;
    end
    ifa.empty = 3'b111; ifa.read_enb = 3'b000;
    step();
    ifa.empty = 3'b010;
    for (int e = 1; e <= 52; e++) begin
      resetn = (e == 20) ? 1'b0 : 1'b1;
      step();
      exp = (e == 50) ? 3'b101 : 3'b000;
      if (ifa.soft_reset !== exp) $display("FAIL indep_midreset edge %0d got %b want %b", e, ifa.soft_reset, exp);
      else pass_cnt++;
      total_cnt++;
    end
    resetn = 1'b1;
    ifa.empty = 3'b111;
    step();
    ifa.empty = 3'b101;
    for (int e = 1; e <= 31; e++) begin
      resetn = (e == 30) ? 1'b0 : 1'b1;
      step();
      if (ifa.soft_reset !== 3'b000) $display("FAIL reset_cancels_pulse edge %0d got %b want 000", e, ifa.soft_reset);
      else pass_cnt++;
      total_cnt++;
    end
    resetn = 1'b1;
    ifa.empty = 3'b111;
    step();
  endtask

  task automatic test_scaled();
    logic [3:0] exp;
    ifb.detect_add = 1'b1; ifb.data_in = 2'd3;
    step();
    ifb.detect_add = 1'b0; ifb.write_enb_reg = 1'b1; ifb.full = 4'b1000;
    #1;
    if (ifb.write_enb !== 4'b1000) $display("FAIL scaled_write_enb got %b want 1000", ifb.write_enb);
    else pass_cnt++;
    total_cnt++;
    if (ifb.addr_err !== 1'b0) $display("FAIL scaled_addr_err got %b want 0", ifb.addr_err);
    else pass_cnt++;
    total_cnt++;
    if (ifb.fifo_full !== 1'b1) $display("FAIL scaled_fifo_full got %b want 1", ifb.fifo_full);
    else pass_cnt++;
    total_cnt++;
    ifb.write_enb_reg = 1'b0; ifb.full = 4'b0000;
    ifb.empty = 4'b0111; ifb.read_enb = 4'b0000;
    for (int e = 1; e <= 12; e++) begin
      step();
      exp = (e % 4 == 0) ? 4'b1000 : 4'b0000;
      if (ifb.soft_reset !== exp) $display("FAIL scaled_timeout edge %0d got %b want %b", e, ifb.soft_reset, exp);
      else pass_cnt++;
      total_cnt++;
    end
    ifb.empty = 4'b1111;
    step();
  endtask

  task automatic test_random();
    logic [2:0] exp_we_a;
    logic       exp_ff_a;
    logic [3:0] exp_we_b;
    logic       exp_ff_b;
    for (int n = 0; n < 400; n++) begin
      resetn            = ($urandom_range(0, 63) != 0);
      ifa.detect_add    = ($urandom_range(0, 3) == 0);
      ifa.data_in       = 2'($urandom);
      ifa.write_enb_reg = 1'($urandom);
      ifa.full          = 3'($urandom);
      if ($urandom_range(0, 15) == 0) ifa.empty = 3'($urandom);
      for (int i = 0; i < 3; i++) ifa.read_enb[i] = ($urandom_range(0, 31) == 0);
      ifb.detect_add    = ($urandom_range(0, 3) == 0);
      ifb.data_in       = 2'($urandom);
      ifb.write_enb_reg = 1'($urandom);
      ifb.full          = 4'($urandom);
      if ($urandom_range(0, 15) == 0) ifb.empty = 4'($urandom);
      for (int i = 0; i < 4; i++) ifb.read_enb[i] = ($urandom_range(0, 31) == 0);
      #1;
      exp_we_a = (ifa.write_enb_reg && !m_err_a) ? (3'b001 << m_addr_a) : 3'b000;
      exp_ff_a = !m_err_a && (ifa.full[m_addr_a % 3] === 1'b1);
      exp_we_b = (ifb.write_enb_reg && !m_err_b) ? (4'b0001 << m_addr_b) : 4'b0000;
      exp_ff_b = !m_err_b && (ifb.full[m_addr_b % 4] === 1'b1);
      if (ifa.write_enb !== exp_we_a) $display("FAIL rand_a_write_enb cyc %0d got %b want %b", n, ifa.write_enb, exp_we_a);
      else pass_cnt++;
      total_cnt++;
      if (ifa.fifo_full !== exp_ff_a) $display("FAIL rand_a_fifo_full cyc %0d got %b want %b", n, ifa.fifo_full, exp_ff_a);
      else pass_cnt++;
      total_cnt++;
      if (ifa.vld_out !== ~ifa.empty) $display("FAIL rand_a_vld_out cyc %0d got %b want %b", n, ifa.vld_out, ~ifa.empty);
      else pass_cnt++;
      total_cnt++;
      if (ifa.addr_err !== m_err_a) $display("FAIL rand_a_addr_err cyc %0d got %b want %b", n, ifa.addr_err, m_err_a);
      else pass_cnt++;
      total_cnt++;
      if (ifa.soft_reset !== m_sr_a) $display("FAIL rand_a_soft_reset cyc %0d got %b want %b", n, ifa.soft_reset, m_sr_a);
      else pass_cnt++;
      total_cnt++;
      if (ifb.write_enb !== exp_we_b) $display("FAIL rand_b_write_enb cyc %0d got %b want %b", n, ifb.write_enb, exp_we_b);
      else pass_cnt++;
      total_cnt++;
      if (ifb.fifo_full !== exp_ff_b) $display("FAIL rand_b_fifo_full cyc %0d got %b want %b", n, ifb.fifo_full, exp_ff_b);
      else pass_cnt++;
      total_cnt++;
      if (ifb.vld_out !== ~ifb.empty) $display("FAIL rand_b_vld_out cyc %0d got %b want %b", n, ifb.vld_out, ~ifb.empty);
      else pass_cnt++;
      total_cnt++;
      if (ifb.addr_err !== m_err_b) $display("FAIL rand_b_addr_err cyc %0d got %b want %b", n, ifb.addr_err, m_err_b);
      else pass_cnt++;
      total_cnt++;
      if (ifb.soft_reset !== m_sr_b) $display("FAIL rand_b_soft_reset cyc %0d got %b want %b", n, ifb.soft_reset, m_sr_b);
      else pass_cnt++;
      total_cnt++;
      step();
    end
  endtask

  initial begin
    resetn = 1'b0;
    ifa.data_in = '0; ifa.detect_add = 1'b0; ifa.write_enb_reg = 1'b0;
    ifa.full = '0; ifa.empty = '1; ifa.read_enb = '0;
    ifb.data_in = '0; ifb.detect_add = 1'b0; ifb.write_enb_reg = 1'b0;
    ifb.full = '0; ifb.empty = '1; ifb.read_enb = '0;
    m_addr_a = 0; m_err_a = 0; m_sr_a = '0;
    m_addr_b = 0; m_err_b = 0; m_sr_b = '0;
    for (int i = 0; i < 3; i++) run_a[i] = 0;
    for (int i = 0; i < 4; i++) run_b[i] = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_addr_in_range();
    test_same_cycle();
    test_invalid_addr();
    test_timeout();
    test_independent();
    test_scaled();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
